// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: walks one digit at a time through ON/GAP
// phases, feeding a shared BCD decoder from shadow registers that only update at frame start.
module display_scan_ctrl #(
    parameter int NDIG  = 4,
    parameter int DIV_W = 16,
    parameter int BLANK = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [DIV_W-1:0]     div_val,
    input  logic [4*NDIG-1:0]    digits_in,
    input  logic                 load,
    input  logic                 lz_en,
    output logic [3:0]           bcd_out,
    output logic                 blank_out,
    output logic [NDIG-1:0]      digit_en,
    output logic                 frame_done,
    output logic                 load_ack
);
    localparam int IW = $clog2(NDIG);
    localparam int GW = (BLANK > 1) ? $clog2(BLANK + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_t;

    state_t              r_state, w_state;
    logic [IW-1:0]       r_idx, w_idx, w_nidx;
    logic [DIV_W-1:0]    r_cnt, w_cnt, r_dwell, w_dwell, w_d;
    logic [GW-1:0]       r_gcnt, w_gcnt;
    logic [4*NDIG-1:0]   r_shadow, w_shadow;
    logic                r_pend, w_pend;
    logic                w_fstart, w_ack;
    logic [NDIG-1:0]     w_hz;
    logic                w_z, w_on;
    logic [3:0]          w_bcd;
    logic                w_blank;
    logic [NDIG-1:0]     w_en;

    always_comb begin
        w_d      = (div_val == '0) ? DIV_W'(1) : div_val;
        w_nidx   = (r_idx == IW'(NDIG - 1)) ? '0 : r_idx + 1'b1;
        w_state  = r_state;
        w_idx    = r_idx;
        w_cnt    = r_cnt;
        w_dwell  = r_dwell;
        w_gcnt   = r_gcnt;
        w_shadow = r_shadow;
        w_pend   = r_pend | load;
        w_fstart = 1'b0;
        w_ack    = 1'b0;
        if (!ena) begin
            w_state = S_IDLE;
            w_idx   = '0;
            w_cnt   = '0;
            w_gcnt  = '0;
            // A fresh load seen while idle is taken immediately; a pending one waits for the frame.
            if (r_state == S_IDLE && load) begin
                w_shadow = digits_in;
                w_ack    = 1'b1;
                w_pend   = 1'b0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state  = S_ON;
                    w_idx    = '0;
                    w_cnt    = DIV_W'(1);
                    w_dwell  = w_d;
                    w_fstart = 1'b1;
                end
                S_ON: begin
                    if (r_cnt < r_dwell) begin
                        w_cnt = r_cnt + 1'b1;
                    end else if (BLANK > 0) begin
                        w_state = S_GAP;
                        w_gcnt  = GW'(1);
                    end else begin
                        w_idx    = w_nidx;
                        w_cnt    = DIV_W'(1);
                        w_dwell  = w_d;
                        w_fstart = (w_nidx == '0);
                    end
                end
                S_GAP: begin
                    if (r_gcnt < GW'(BLANK)) begin
                        w_gcnt = r_gcnt + 1'b1;
                    end else begin
                        w_state  = S_ON;
                        w_idx    = w_nidx;
                        w_cnt    = DIV_W'(1);
                        w_dwell  = w_d;
                        w_fstart = (w_nidx == '0);
                    end
                end
                default: w_state = S_IDLE;
            endcase
            if (w_fstart && w_pend) begin
                w_shadow = digits_in;
                w_ack    = 1'b1;
                w_pend   = 1'b0;
            end
        end
    end

    // w_hz[i]: every shadow digit from the top down to i is zero.
    always_comb begin
        w_z  = 1'b1;
        w_hz = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            w_z     = w_z & (w_shadow[4*i +: 4] == 4'd0);
            w_hz[i] = w_z;
        end
    end

    always_comb begin
        w_on    = (w_state == S_ON);
        w_bcd   = w_on ? w_shadow[{w_idx, 2'b00} +: 4] : 4'd0;
        w_blank = !w_on || (lz_en && (w_idx != '0) && w_hz[w_idx]);
        w_en    = w_on ? (NDIG'(1) << w_idx) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_dwell    <= '0;
            r_gcnt     <= '0;
            r_shadow   <= '0;
            r_pend     <= 1'b0;
            bcd_out    <= 4'd0;
            blank_out  <= 1'b1;
            digit_en   <= '0;
            frame_done <= 1'b0;
            load_ack   <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_idx      <= w_idx;
            r_cnt      <= w_cnt;
            r_dwell    <= w_dwell;
            r_gcnt     <= w_gcnt;
            r_shadow   <= w_shadow;
            r_pend     <= w_pend;
            bcd_out    <= w_bcd;
            blank_out  <= w_blank;
            digit_en   <= w_en;
            frame_done <= w_fstart;
            load_ack   <= w_ack;
        end
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench: the stimulus process queues the expected outputs for each cycle,
// a monitor pops and compares them after every rising edge.
module tb_display_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst, rst2, ena, load, lz_en;
    logic [15:0] div_val, digits_in;
    logic [15:0] div0 = 16'd0;
    logic [3:0]  bcd_out, bcd2, digit_en, en2;
    logic        blank_out, bl2, fd, fd2, ak, ak2;

    typedef struct {
        string      nm;
        bit         d;
        bit         mb;
        logic [3:0] en;
        logic [3:0] bcd;
        logic       bl;
        logic       fd;
        logic       ak;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    display_scan_ctrl #(.NDIG(4), .DIV_W(16), .BLANK(2)) u_dut (
        .clk(clk), .rst(rst), .ena(ena), .div_val(div_val), .digits_in(digits_in),
        .load(load), .lz_en(lz_en), .bcd_out(bcd_out), .blank_out(blank_out),
        .digit_en(digit_en), .frame_done(fd), .load_ack(ak));

    display_scan_ctrl #(.NDIG(4), .DIV_W(16), .BLANK(0)) u_dut0 (
        .clk(clk), .rst(rst2), .ena(1'b1), .div_val(div0), .digits_in(digits_in),
        .load(load), .lz_en(lz_en), .bcd_out(bcd2), .blank_out(bl2),
        .digit_en(en2), .frame_done(fd2), .load_ack(ak2));

    function automatic void pushx(string nm, bit d, logic [3:0] en, logic [3:0] bcd,
                                  logic bl, logic f, logic a);
        exp_t e;
        e.nm = nm; e.d = d; e.mb = 1'b1;
        e.en = en; e.bcd = bcd; e.bl = bl; e.fd = f; e.ak = a;
        q.push_back(e);
    endfunction

    // Expected outputs for the main instance (D=3, BLANK=2, 20-cycle frame) at frame offset pos.
    function automatic void pushm(string nm, int pos, logic [15:0] s, bit lz, bit a);
        int p, d, r;
        logic [3:0] en, bcd;
        logic bl;
        p = pos % 20; d = p / 5; r = p % 5;
        if (r < 3) begin
            en  = 4'(1 << d);
            bcd = s[4*d +: 4];
            bl  = lz && (d != 0) && ((s >> (4*d)) == 16'h0);
        end else begin
            en = 4'd0; bcd = 4'd0; bl = 1'b1;
        end
        pushx(nm, 1'b0, en, bcd, bl, (p == 0), a);
    endfunction

    function automatic logic [15:0] sh_a(int k);
        if (k < 60)       return 16'h0000;
        else if (k < 80)  return 16'h4321;
        else if (k < 120) return 16'h8765;
        else if (k < 140) return 16'h0050;
        else              return 16'h0000;
    endfunction

    // Monitor
    initial begin
        exp_t e;
        logic [3:0] a_en, a_bcd;
        logic a_bl, a_fd, a_ak, ok;
        forever begin
            @(posedge clk);
            #2;
            total++;
            if (!$onehot0(digit_en) || !$onehot0(en2)) begin
                bad++;
                $display("FAIL onehot: got en=%b en2=%b, want at most one bit set", digit_en, en2);
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.d) begin
                    a_en = en2; a_bcd = bcd2; a_bl = bl2; a_fd = fd2; a_ak = ak2;
                end else begin
                    a_en = digit_en; a_bcd = bcd_out; a_bl = blank_out; a_fd = fd; a_ak = ak;
                end
                ok = (a_en === e.en) && (a_fd === e.fd) && (a_ak === e.ak) &&
                     (!e.mb || ((a_bcd === e.bcd) && (a_bl === e.bl)));
                total++;
                if (!ok) begin
                    bad++;
                    $display("FAIL %s: got en=%b bcd=%h bl=%b fd=%b ak=%b want en=%b bcd=%h bl=%b fd=%b ak=%b",
                             e.nm, a_en, a_bcd, a_bl, a_fd, a_ak, e.en, e.bcd, e.bl, e.fd, e.ak);
                end
            end
        end
    end

    // Stimulus
    initial begin
        rst = 1'b1; rst2 = 1'b1; ena = 1'b0; load = 1'b0; lz_en = 1'b0;
        div_val = 16'd3; digits_in = 16'h0000;
        repeat (2) begin
            @(negedge clk);
            pushx("reset", 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        end

        // Scan, loads at/around frame boundaries, leading-zero suppression
        for (int k = 0; k <= 190; k++) begin
            @(negedge clk);
            case (k)
                0:   begin rst = 1'b0; ena = 1'b1; end
                45:  begin digits_in = 16'h4321; load = 1'b1; end
                80:  begin digits_in = 16'h8765; load = 1'b1; end
                90:  digits_in = 16'h1111;
                105: begin digits_in = 16'h0050; load = 1'b1; lz_en = 1'b1; end
                125: begin digits_in = 16'h0000; load = 1'b1; end
                160: lz_en = 1'b0;
                185: begin digits_in = 16'h0909; load = 1'b1; end
                default: load = 1'b0;
            endcase
            pushm($sformatf("scan k=%0d", k), k, sh_a(k), (k >= 105 && k < 160),
                  (k == 60 || k == 80 || k == 120 || k == 140));
        end

        // ena dropped mid-dwell on idx 2 with a load pending
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) ena = 1'b0;
            pushx($sformatf("ena_off %0d", k), 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        end

        // Re-enable, then reset during GAP with a new load pending
        for (int j = 0; j <= 25; j++) begin
            @(negedge clk);
            case (j)
                0: ena = 1'b1;
                1: begin digits_in = 16'h7777; load = 1'b1; end
                4: rst = 1'b1;
                5: rst = 1'b0;
                default: load = 1'b0;
            endcase
            if (j < 4)
                pushm($sformatf("reena j=%0d", j), j, 16'h0909, 1'b0, (j == 0));
            else if (j == 4)
                pushx("rst_in_gap", 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
            else
                pushm($sformatf("post_rst m=%0d", j - 5), j - 5, 16'h0000, 1'b0, 1'b0);
        end

        // div_val=0, BLANK=0: one cycle per digit, back to back
        for (int n = 0; n < 9; n++) begin
            @(negedge clk);
            if (n == 0) rst2 = 1'b0;
            pushx($sformatf("nogap n=%0d", n), 1'b1, 4'(1 << (n % 4)), 4'd0, 1'b0,
                  (n % 4 == 0), 1'b0);
        end

        repeat (3) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d queued, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexed scan controller for a multi-digit 7-segment display. One shared BCD-to-7-segment decoder drives all digits.
- Each cycle, the block presents one digit's BCD value and blank flag to the shared decoder, and drives the matching one-hot common enable.
- An inter-digit blanking gap prevents ghosting.
- Sits between the counter datapath, which supplies the BCD digits, and the shared decoder and pad drivers. Updates from the counter are taken only at frame boundaries so the display never tears.

Parameters:
- NDIG, 4, number of multiplexed digits. Legal range 2..8. Digit NDIG-1 is the most significant.
- DIV_W, 16, width of the dwell-count input.
- BLANK, 2, number of all-off gap cycles between digits. 0 is legal and means no gap.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- ena  input  1  scan enable.
- div_val  input  DIV_W  dwell cycles per digit; 0 is treated as 1.
- digits_in  input  4*NDIG  packed BCD digits; digit i is bits [4i+3:4i].
- load  input  1  single-cycle request to capture digits_in.
- lz_en  input  1  leading-zero suppression enable.
- bcd_out  output  4  BCD code to the shared decoder.
- blank_out  output  1  1 = downstream gates all segments off.
- digit_en  output  NDIG  one-hot digit common enable, active-high.
- frame_done  output  1  1-cycle pulse at the start of each frame.
- load_ack  output  1  1-cycle pulse when shadow registers are updated.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, idx=0, dwell counter=0, shadow=0, pending=0, bcd_out=0, blank_out=1, digit_en=0, frame_done=0, load_ack=0.
- rst has priority over every other input.
- States:
  - IDLE: digit_en=0, blank_out=1. If ena=1 at the clock edge, the next cycle is ON with idx=0.
  - ON: digit_en=(1<<idx) for exactly D=max(div_val,1) cycles. div_val is sampled at entry to ON, so mid-dwell changes take effect at the next digit. On the last dwell cycle, the next state is GAP if BLANK>0; otherwise it is ON for the next idx.
  - GAP: digit_en=0, blank_out=1, for exactly BLANK cycles. Then idx advances and the state returns to ON.
- idx advance: idx is 0..NDIG-1 and wraps NDIG-1 to 0.
- Frame period: NDIG*(D+BLANK) cycles.
- frame_done: asserted on the first ON cycle of idx=0, both on leaving IDLE and on every wrap.
- bcd_out: equals shadow digit idx during ON, and 0 otherwise.
- blank_out in ON:
  - blank_out=1 when lz_en=1 and every shadow digit from NDIG-1 down to idx equals 0. Digit 0 is never suppressed.
  - Otherwise blank_out=0.
  - lz_en is sampled combinationally into the registered output each cycle.
- Shadow registers: BCD values of 10..15 pass through unchanged; the decoder shows them as 'F'.
- Load handshake:
  - A load pulse sets pending.
  - While scanning, shadow<=digits_in is captured on the cycle the frame starts, i.e. the cycle entering ON idx=0. frame_done and load_ack pulse together on that cycle, and pending clears.
  - digits_in is sampled at that capture edge, not at the load edge.
  - If load and the frame-start edge coincide, capture happens at that edge.
  - If load arrives in IDLE, the capture is on the next edge, load_ack pulses on that cycle, and pending clears.
  - Repeated loads before capture merge into one ack.
- ena deassert: if ena=0 at the edge, the next cycle is IDLE with idx=0, dwell counter cleared, digit_en=0. pending is retained.
- Reset during a scan: all state returns to reset values at the next edge and pending is lost.
- The dwell counter is DIV_W bits and never overflows; it counts 1..D inclusive.

Test Plan:
1. Basic scan: NDIG=4, BLANK=2, div_val=3, ena=1 after reset.
   - digit_en = 0001 for 3 cycles, then 0000 for 2, 0010 for 3, 0000 for 2, ... then 1000.
   - frame_done pulses every 20 cycles.
   - No two enable bits are ever simultaneously 1.
2. Load at a frame boundary: digits_in=0x4321, load pulsed mid-frame.
   - Display is unchanged until the next frame start.
   - At that start, load_ack and frame_done pulse together.
   - bcd_out then reads 1,2,3,4 on idx 0..3.
   - A load asserted exactly on the frame-start edge is captured at that same edge.
3. Leading-zero suppression: shadow=0x0050, lz_en=1.
   - idx3 and idx2 give blank_out=1; idx1 gives bcd 5, blank 0; idx0 gives bcd 0, blank 0.
   - shadow=0x0000 gives only idx0 unblanked.
   - With lz_en=0, all four digits are unblanked.
4. div_val=0 with BLANK=0: each digit is on for 1 cycle, back to back.
   - digit_en rotates 0001, 0010, 0100, 1000, ...
   - frame_done pulses every 4 cycles.
5. ena dropped at idx=2 mid-dwell: the next cycle gives digit_en=0 and blank_out=1.
   - A pending load is kept.
   - Re-enabling starts at idx=0 with frame_done and load_ack pulsing.
6. rst asserted during GAP with pending=1: the next cycle has all outputs at reset values, shadow=0 and no load_ack.
